// File: rtl/ysyx_22040895_ifu_pkg.sv
// ysyx_22040895_ifu_pkg: shared IFU state encodings, reset PC, nop word and decode field widths
package ysyx_22040895_ifu_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int OPCODE_W = 7;
  localparam int FUNC3_W = 3;
  localparam int FUNC7_W = 7;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_TRAP = 2'd3
  } state_t;
endpackage

// File: rtl/ysyx_22040895_ifu_pc_reg.sv
// ysyx_22040895_pc_reg: PC register with next-PC mux (pc+4 or redirect target); ports clk, rst, load, jump, target in, pc out; YSYX_22040895_IFU_MISALIGN_EN keeps target low bits, otherwise they are forced to 00
module ysyx_22040895_pc_reg #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] tgt;
`ifdef YSYX_22040895_IFU_MISALIGN_EN
  assign tgt = target;
`else
  assign tgt = target & ~XLEN'(3);
`endif
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else if (load) pc <= jump ? tgt : pc + XLEN'(4);
  end
endmodule

// File: rtl/ysyx_22040895_ifu.sv
// ysyx_22040895_ifu: instruction fetch unit; imem req/resp in, inst/pc/fields out to decode, redirect in from execute, misalign_o_ifu trap flag (live only with YSYX_22040895_IFU_MISALIGN_EN)
module ysyx_22040895_ifu
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid_o_ifu,
  input  logic                imem_req_ready_i_ifu,
  output logic [XLEN-1:0]     imem_addr_o_ifu,
  input  logic                imem_resp_valid_i_ifu,
  input  logic [31:0]         imem_resp_data_i_ifu,
  output logic                inst_valid_o_ifu,
  input  logic                inst_ready_i_ifu,
  output logic [31:0]         inst_o_ifu,
  output logic [XLEN-1:0]     pc_o_ifu,
  output logic [OPCODE_W-1:0] opcode_o_ifu,
  output logic [FUNC3_W-1:0]  func3_o_ifu,
  output logic [FUNC7_W-1:0]  func7_o_ifu,
  input  logic                jump_branch_i_ifu,
  input  logic [XLEN-1:0]     target_i_ifu,
  output logic                misalign_o_ifu
);
  state_t state;
  logic [31:0] inst;
  logic [XLEN-1:0] pc;
  logic misalign, trap, load;
`ifdef YSYX_22040895_IFU_MISALIGN_EN
  assign trap = jump_branch_i_ifu & |target_i_ifu[1:0];
`else
  assign trap = 1'b0;
`endif
  assign load = (state == S_OUT) & inst_ready_i_ifu;
  ysyx_22040895_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(load), .jump(jump_branch_i_ifu), .target(target_i_ifu), .pc(pc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      inst <= NOP;
      misalign <= 1'b0;
    end else begin
      case (state)
        S_REQ: if (imem_req_ready_i_ifu) state <= S_WAIT;
        S_WAIT: if (imem_resp_valid_i_ifu) begin
          inst <= imem_resp_data_i_ifu;
          state <= S_OUT;
        end
        S_OUT: if (inst_ready_i_ifu) begin
          state <= trap ? S_TRAP : S_REQ;
          misalign <= trap;
        end
        S_TRAP: state <= S_TRAP;
      endcase
    end
  end
  assign imem_req_valid_o_ifu = state == S_REQ;
  assign imem_addr_o_ifu = pc;
  assign inst_valid_o_ifu = state == S_OUT;
  assign inst_o_ifu = inst;
  assign pc_o_ifu = pc;
  assign opcode_o_ifu = inst[6:0];
  assign func3_o_ifu = inst[14:12];
  assign func7_o_ifu = inst[31:25];
  assign misalign_o_ifu = misalign;
endmodule
